// File: rtl/fnd_mode_ctrl.sv
// Display-mode sequencer for the FND source mux: steps on buttons or a dwell
// timer, blanks the FND on every switch and paces the sensor start pulses.
module fnd_mode_ctrl #(
    parameter int unsigned BLANK_CYCLES = 100_000,
    parameter int unsigned AUTO_DWELL   = 300_000_000,
    parameter int unsigned SR04_PERIOD  = 6_000_000,
    parameter int unsigned DHT11_PERIOD = 200_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    output logic [1:0] current_active_mode,
    output logic       fnd_blank,
    output logic       sr04_start,
    output logic       dht11_start
);

    localparam int unsigned TRIG_MAX = (SR04_PERIOD > DHT11_PERIOD) ? SR04_PERIOD : DHT11_PERIOD;
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int DWELL_W = $clog2(AUTO_DWELL);
    localparam int TRIG_W  = $clog2(TRIG_MAX);

    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_DWELL - 1);
    localparam logic [TRIG_W-1:0]  SR04_LAST  = TRIG_W'(SR04_PERIOD - 1);
    localparam logic [TRIG_W-1:0]  DHT11_LAST = TRIG_W'(DHT11_PERIOD - 1);

    localparam logic [1:0] MODE_WATCH = 2'b00;
    localparam logic [1:0] MODE_SR04  = 2'b01;
    localparam logic [1:0] MODE_DHT11 = 2'b10;
    localparam logic [1:0] MODE_BAD   = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_BLANK
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               blank_q, blank_d;
    logic               sr04_q, sr04_d;
    logic               dht11_q, dht11_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [TRIG_W-1:0]  trig_cnt_q, trig_cnt_d;

    logic       auto_hit;
    logic       step_req;
    logic       step_back;
    logic [1:0] mode_fwd;
    logic [1:0] mode_rev;
    logic [TRIG_W-1:0] period_last;

    // Both buttons together cancel each other and also veto an auto expiry.
    assign auto_hit    = auto_en && (dwell_q == DWELL_LAST);
    assign step_back   = btn_prev & ~btn_next;
    assign step_req    = (btn_next ^ btn_prev) | (auto_hit & ~(btn_next & btn_prev));
    assign period_last = (mode_q == MODE_SR04) ? SR04_LAST : DHT11_LAST;

    always_comb begin
        mode_fwd = MODE_WATCH;
        mode_rev = MODE_WATCH;
        case (mode_q)
            MODE_WATCH: begin mode_fwd = MODE_SR04;  mode_rev = MODE_DHT11; end
            MODE_SR04:  begin mode_fwd = MODE_DHT11; mode_rev = MODE_WATCH; end
            MODE_DHT11: begin mode_fwd = MODE_WATCH; mode_rev = MODE_SR04;  end
            default:    begin mode_fwd = MODE_WATCH; mode_rev = MODE_WATCH; end
        endcase
    end

    // NOTE: every next-state signal gets a default before any branch, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        blank_d     = 1'b0;
        sr04_d      = 1'b0;
        dht11_d     = 1'b0;
        dwell_d     = '0;
        blank_cnt_d = '0;
        trig_cnt_d  = '0;

        if (mode_q == MODE_BAD) begin
            state_d = ST_RUN;
            mode_d  = MODE_WATCH;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (step_req) begin
                        state_d = ST_BLANK;
                        mode_d  = step_back ? mode_rev : mode_fwd;
                        blank_d = 1'b1;
                    end else begin
                        if (auto_en && !auto_hit) begin
                            dwell_d = dwell_q + 1'b1;
                        end
                        if (mode_q != MODE_WATCH) begin
                            if (trig_cnt_q == period_last) begin
                                sr04_d  = (mode_q == MODE_SR04);
                                dht11_d = (mode_q == MODE_DHT11);
                            end else begin
                                trig_cnt_d = trig_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        // Entry pulse for the newly displayed sensor.
                        state_d = ST_RUN;
                        sr04_d  = (mode_q == MODE_SR04);
                        dht11_d = (mode_q == MODE_DHT11);
                    end else begin
                        blank_d     = 1'b1;
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            mode_q      <= MODE_WATCH;
            blank_q     <= 1'b0;
            sr04_q      <= 1'b0;
            dht11_q     <= 1'b0;
            dwell_q     <= '0;
            blank_cnt_q <= '0;
            trig_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            blank_q     <= blank_d;
            sr04_q      <= sr04_d;
            dht11_q     <= dht11_d;
            dwell_q     <= dwell_d;
            blank_cnt_q <= blank_cnt_d;
            trig_cnt_q  <= trig_cnt_d;
        end
    end

    assign current_active_mode = mode_q;
    assign fnd_blank           = blank_q;
    assign sr04_start          = sr04_q;
    assign dht11_start         = dht11_q;

endmodule

// File: tb/tb_fnd_mode_ctrl.sv
// Bench for fnd_mode_ctrl: per-cycle vector tables through a scoreboard queue,
// plus hand-written reset-in-blank and illegal-mode upset sequences.
`timescale 1ns/1ps
module tb_fnd_mode_ctrl;

    localparam int unsigned BLANK_CYCLES = 4;
    localparam int unsigned AUTO_DWELL   = 20;
    localparam int unsigned SR04_PERIOD  = 10;
    localparam int unsigned DHT11_PERIOD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [1:0] current_active_mode;
    logic       fnd_blank;
    logic       sr04_start;
    logic       dht11_start;

    fnd_mode_ctrl #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .AUTO_DWELL   (AUTO_DWELL),
        .SR04_PERIOD  (SR04_PERIOD),
        .DHT11_PERIOD (DHT11_PERIOD)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .btn_next            (btn_next),
        .btn_prev            (btn_prev),
        .auto_en             (auto_en),
        .current_active_mode (current_active_mode),
        .fnd_blank           (fnd_blank),
        .sr04_start          (sr04_start),
        .dht11_start         (dht11_start)
    );

    always #5 clk = ~clk;

    // One record = rep cycles; buttons pulse on the first cycle only.
    typedef struct {
        int         rep;
        logic       bn;
        logic       bp;
        logic       ae;
        logic [1:0] mode;
        logic       blank;
        logic       sr;
        logic       dht;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       blank;
        logic       sr;
        logic       dht;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string name, input logic [1:0] m, input logic bl,
                                 input logic sr, input logic dh);
        check({name, ".mode"},  32'(current_active_mode), 32'(m));
        check({name, ".blank"}, 32'(fnd_blank),           32'(bl));
        check({name, ".sr04"},  32'(sr04_start),          32'(sr));
        check({name, ".dht11"}, 32'(dht11_start),         32'(dh));
    endtask

    function automatic void add(input int rep, input logic bn, input logic bp, input logic ae,
                                input logic [1:0] m, input logic bl, input logic sr, input logic dh);
        vecs.push_back('{rep, bn, bp, ae, m, bl, sr, dh});
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic run_table(input string phase);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                btn_next = (r == 0) ? vecs[i].bn : 1'b0;
                btn_prev = (r == 0) ? vecs[i].bp : 1'b0;
                auto_en  = vecs[i].ae;
                sb.push_back('{vecs[i].mode, vecs[i].blank, vecs[i].sr, vecs[i].dht});
                @(negedge clk);
                e = sb.pop_front();
                check_outputs($sformatf("%s v%0d.%0d", phase, i, r), e.mode, e.blank, e.sr, e.dht);
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        vecs.delete();
    endtask

    task automatic apply_reset(input string phase);
        rst_n    = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        auto_en  = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs({phase, " in_reset"}, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded bound", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Button stepping, periodic triggers, conflicts and presses during blank.
        apply_reset("btn");
        add(4,  0, 0, 0, 2'd0, 0, 0, 0);
        add(1,  1, 0, 0, 2'd1, 1, 0, 0);
        add(3,  0, 0, 0, 2'd1, 1, 0, 0);
        add(1,  0, 0, 0, 2'd1, 0, 1, 0);
        add(9,  0, 0, 0, 2'd1, 0, 0, 0);
        add(1,  0, 0, 0, 2'd1, 0, 1, 0);
        add(9,  0, 0, 0, 2'd1, 0, 0, 0);
        add(1,  0, 0, 0, 2'd1, 0, 1, 0);
        add(5,  0, 0, 0, 2'd1, 0, 0, 0);
        add(1,  0, 1, 0, 2'd0, 1, 0, 0);
        add(3,  0, 0, 0, 2'd0, 1, 0, 0);
        add(1,  0, 0, 0, 2'd0, 0, 0, 0);
        add(12, 0, 0, 0, 2'd0, 0, 0, 0);
        add(1,  0, 1, 0, 2'd2, 1, 0, 0);
        add(3,  0, 0, 0, 2'd2, 1, 0, 0);
        add(1,  0, 0, 0, 2'd2, 0, 0, 1);
        add(15, 0, 0, 0, 2'd2, 0, 0, 0);
        add(1,  0, 0, 0, 2'd2, 0, 0, 1);
        add(15, 0, 0, 0, 2'd2, 0, 0, 0);
        add(1,  0, 0, 0, 2'd2, 0, 0, 1);
        add(3,  0, 0, 0, 2'd2, 0, 0, 0);
        add(1,  1, 0, 0, 2'd0, 1, 0, 0);
        add(3,  0, 0, 0, 2'd0, 1, 0, 0);
        add(1,  0, 0, 0, 2'd0, 0, 0, 0);
        add(3,  0, 0, 0, 2'd0, 0, 0, 0);
        add(1,  1, 0, 0, 2'd1, 1, 0, 0);
        add(3,  0, 0, 0, 2'd1, 1, 0, 0);
        add(1,  0, 0, 0, 2'd1, 0, 1, 0);
        add(4,  0, 0, 0, 2'd1, 0, 0, 0);
        add(1,  1, 1, 0, 2'd1, 0, 0, 0);
        add(3,  0, 0, 0, 2'd1, 0, 0, 0);
        add(1,  1, 0, 0, 2'd2, 1, 0, 0);
        add(1,  1, 0, 0, 2'd2, 1, 0, 0);
        add(1,  1, 0, 0, 2'd2, 1, 0, 0);
        add(1,  0, 0, 0, 2'd2, 1, 0, 0);
        add(1,  0, 0, 0, 2'd2, 0, 0, 1);
        add(3,  0, 0, 0, 2'd2, 0, 0, 0);
        run_table("btn");

        // Auto-advance round trip, auto_en drop, button coinciding with expiry.
        apply_reset("auto");
        add(19, 0, 0, 1, 2'd0, 0, 0, 0);
        add(1,  0, 0, 1, 2'd1, 1, 0, 0);
        add(3,  0, 0, 1, 2'd1, 1, 0, 0);
        add(1,  0, 0, 1, 2'd1, 0, 1, 0);
        add(9,  0, 0, 1, 2'd1, 0, 0, 0);
        add(1,  0, 0, 1, 2'd1, 0, 1, 0);
        add(9,  0, 0, 1, 2'd1, 0, 0, 0);
        add(1,  0, 0, 1, 2'd2, 1, 0, 0);
        add(3,  0, 0, 1, 2'd2, 1, 0, 0);
        add(1,  0, 0, 1, 2'd2, 0, 0, 1);
        add(15, 0, 0, 1, 2'd2, 0, 0, 0);
        add(1,  0, 0, 1, 2'd2, 0, 0, 1);
        add(3,  0, 0, 1, 2'd2, 0, 0, 0);
        add(1,  0, 0, 1, 2'd0, 1, 0, 0);
        add(3,  0, 0, 1, 2'd0, 1, 0, 0);
        add(1,  0, 0, 1, 2'd0, 0, 0, 0);
        add(14, 0, 0, 1, 2'd0, 0, 0, 0);
        add(2,  0, 0, 0, 2'd0, 0, 0, 0);
        add(19, 0, 0, 1, 2'd0, 0, 0, 0);
        add(1,  1, 0, 1, 2'd1, 1, 0, 0);
        add(3,  0, 0, 1, 2'd1, 1, 0, 0);
        add(1,  0, 0, 1, 2'd1, 0, 1, 0);
        add(2,  0, 0, 0, 2'd1, 0, 0, 0);
        run_table("auto");

        // Reset asserted two cycles into the blank of a 00->01 switch.
        apply_reset("rst_mid");
        add(4, 0, 0, 0, 2'd0, 0, 0, 0);
        add(1, 1, 0, 0, 2'd1, 1, 0, 0);
        add(1, 0, 0, 0, 2'd1, 1, 0, 0);
        run_table("rst_mid");
        rst_n = 1'b0;
        #1;
        check_outputs("rst_mid async", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add(16, 0, 0, 0, 2'd0, 0, 0, 0);
        run_table("rst_after");

        // Single-event upset drives the mode register to the illegal 11.
        apply_reset("upset");
        add(2, 0, 0, 0, 2'd0, 0, 0, 0);
        add(1, 1, 0, 0, 2'd1, 1, 0, 0);
        add(3, 0, 0, 0, 2'd1, 1, 0, 0);
        add(1, 0, 0, 0, 2'd1, 0, 1, 0);
        add(3, 0, 0, 0, 2'd1, 0, 0, 0);
        run_table("upset_pre");
        force dut.mode_q = 2'b11;
        #1;
        release dut.mode_q;
        check("upset applied", 32'(current_active_mode), 32'h3);
        @(negedge clk);
        check_outputs("upset recover", 2'b00, 1'b0, 1'b0, 1'b0);
        add(12, 0, 0, 0, 2'd0, 0, 0, 0);
        run_table("upset_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
